// File: rtl/control.sv
// control: 8x8 Game of Life grid register with IDLE/RUN control.
// Loads SEED or advances one generation per RUN edge.
module control #(
  parameter logic [63:0] SEED = 64'h0000_0000_0007_0402
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sel,
  output logic [63:0] q
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] nxt;

  // Next generation for all 64 cells; off-grid cells are dead.
  function automatic logic [63:0] life(
    input logic [63:0] g
  );
    logic [63:0] n;
    logic [3:0]  cnt;
    logic [5:0]  idx;
    logic        inr;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            inr = (r + dr >= 0) && (r + dr < 8)
               && (c + dc >= 0) && (c + dc < 8)
               && !(dr == 0 && dc == 0);
            idx = inr ? 6'(8 * (r + dr) + (c + dc))
                      : 6'd0;
            if (inr)
              cnt = cnt + {3'b000, g[idx]};
          end
        end
        idx = 6'(8 * r + c);
        if (g[idx])
          n[idx] = (cnt == 4'd2) || (cnt == 4'd3);
        else
          n[idx] = (cnt == 4'd3);
      end
    end
    return n;
  endfunction

  // Combinational evolve of the current grid.
  always_comb begin
    nxt = life(q);
  end

  // IDLE/RUN state machine owning the registered grid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state <= RUN;
        end
        RUN: begin
          if (!start)
            state <= IDLE;
          else
            q <= sel ? nxt : SEED;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// tb_control: directed checks of control against
// hand-computed vectors and a padded-border life model.
module tb_control;

  localparam logic [63:0] SEED = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GEN1 = 64'h0000_0000_0206_0500;
  localparam logic [63:0] GEN4 = 64'h0000_0000_0E08_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [63:0] q;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q;

  control #(.SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sel   (sel),
    .q     (q)
  );

  always #5 clk = ~clk;

  // Reference life on a 10x10 array with a dead border ring.
  function automatic logic [63:0] model(
    input logic [63:0] g
  );
    bit          p [0:9][0:9];
    logic [63:0] n;
    int          s;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        p[r][c] = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        p[r+1][c+1] = g[6'(8 * r + c)];
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(p[r+i][c+j]);
        s -= int'(p[r+1][c+1]);
        n[6'(8 * r + c)] = (s == 3)
          || (p[r+1][c+1] && s == 2);
      end
    end
    return n;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s q=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset with start/sel high, mid-cycle.
    start = 1'b1;
    sel   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async", q, 64'h0);
    step();
    chk("reset_hold1", q, 64'h0);
    step();
    chk("reset_hold2", q, 64'h0);

    // Start latency: IDLE->RUN edge, then seed.
    reset = 1'b0;
    start = 1'b1;
    sel   = 1'b0;
    step();
    chk("lat_edge1", q, 64'h0);
    step();
    chk("lat_edge2", q, SEED);

    // Glider generations.
    sel = 1'b1;
    step();
    chk("gen1", q, GEN1);
    exp_q = model(SEED);
    exp_q = model(exp_q);
    step();
    chk("gen2", q, exp_q);
    exp_q = model(exp_q);
    step();
    chk("gen3", q, exp_q);
    step();
    chk("gen4", q, GEN4);

    // Reload, evolve 2, then pause.
    sel = 1'b0;
    step();
    chk("reload", q, SEED);
    sel = 1'b1;
    step();
    step();
    exp_q = model(model(SEED));
    chk("pre_pause", q, exp_q);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sel = i[0];
      step();
      chk("pause_hold", q, exp_q);
    end
    start = 1'b1;
    sel   = 1'b1;
    step();
    chk("resume_edge1", q, exp_q);
    step();
    exp_q = model(exp_q);
    chk("resume_edge2", q, exp_q);

    // Boundary: run glider into the corner.
    for (int i = 0; i < 24; i++) begin
      step();
      exp_q = model(exp_q);
      chk("boundary_gen", q, exp_q);
    end
    chk("no_wrap_b0", {63'h0, q[0]}, 64'h0);

    // Reset mid-run clears grid immediately.
    #2;
    reset = 1'b1;
    #1;
    chk("reset_midrun", q, 64'h0);
    step();
    chk("reset_mid_hold", q, 64'h0);

    // Empty grid stays empty.
    reset = 1'b0;
    start = 1'b1;
    sel   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("empty_grid", q, 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
